seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider for the ALU experiment set.
- Inverse companion to the combinational add/subtract unit: it repeatedly applies trial subtraction to produce quotient and remainder.
- Runs one quotient bit per clock under a start/busy/done handshake.
- Flag outputs mirror the ALU flag style: Zero, plus DivZero in place of overflow.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_trial_sub.sv | 16 +
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and iteration counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The counter must hold 0..WIDTH-1 with headroom for the WIDTH comparison.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_trial_sub.sv
// Combinational (WIDTH+1)-bit trial subtractor used by the restoring divider.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  // An extra top bit captures the borrow; set means the trial went negative.
  assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock under a
// start/busy/done handshake, with Zero and DivZero flags.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Zero,
  output logic             DivZero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             zero_reg, zero_next;
  logic             div_zero_reg, div_zero_next;

  logic [WIDTH:0]   shifted_r;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  // R can reach 2*B-1 after the shift, so it needs one bit beyond WIDTH.
  assign shifted_r = {r_reg, q_reg[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
    .minuend   (shifted_r),
    .subtrahend({1'b0, b_reg}),
    .diff      (diff),
    .borrow    (borrow)
  );

  // On borrow the shifted value is kept (restore); it is below B so fits WIDTH.
  assign r_step = borrow ? shifted_r[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_step = {q_reg[WIDTH-2:0], ~borrow};

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    r_next         = r_reg;
    q_next         = q_reg;
    b_next         = b_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    zero_next      = zero_reg;
    div_zero_next  = div_zero_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          b_next = in_b;
          if (in_b == '0) begin
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = in_a;
            zero_next      = 1'b0;
            div_zero_next  = 1'b1;
          end else begin
            state_next = CALC;
            cnt_next   = '0;
            r_next     = '0;
            q_next     = in_a;
          end
        end
      end
      CALC: begin
        r_next   = r_step;
        q_next   = q_step;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next     = DONE;
          quotient_next  = q_step;
          remainder_next = r_step;
          zero_next      = (q_step == '0);
          div_zero_next  = 1'b0;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      b_reg         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      zero_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      r_reg         <= r_next;
      q_reg         <= q_next;
      b_reg         <= b_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      zero_reg      <= zero_next;
      div_zero_reg  <= div_zero_next;
    end
  end

  assign busy      = (state_reg == CALC);
  assign done      = (state_reg == DONE);
  assign Quotient  = quotient_reg;
  assign Remainder = remainder_reg;
  assign Zero      = zero_reg;
  assign DivZero   = div_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         busy;
  logic         done;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Zero;
  logic         DivZero;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_a     (in_a),
    .in_b     (in_b),
    .busy     (busy),
    .done     (done),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Zero     (Zero),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int dz;
    int lat;
    int busy_n;
    int acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   prev_q = 0;
  int   prev_r = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: every done must match the oldest pending request.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
        end else begin
          mon_e = sb.pop_front();
          $display("txn %0d/%0d -> Q=%0d R=%0d Z=%0b DZ=%0b latency=%0d busy=%0d",
                   mon_e.a, mon_e.b, Quotient, Remainder, Zero, DivZero,
                   cyc - mon_e.acc, busy_cnt);
          check("quotient",  int'(Quotient),  mon_e.q);
          check("remainder", int'(Remainder), mon_e.r);
          check("zero",      int'(Zero),      mon_e.z);
          check("divzero",   int'(DivZero),   mon_e.dz);
          check("latency",   cyc - mon_e.acc, mon_e.lat);
          check("busy_cycles", busy_cnt,      mon_e.busy_n);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_quotient"},  int'(Quotient),  0);
    check({tag, "_remainder"}, int'(Remainder), 0);
    check({tag, "_zero"},      int'(Zero),      0);
    check({tag, "_divzero"},   int'(DivZero),   0);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_done"},      int'(done),      0);
  endtask

  // Issue one request in the first IDLE cycle; returns 1 ns after acceptance.
  task automatic issue(input int a, input int b, input int eq, input int er,
                       input int ez, input int edz, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b, required idle", busy, done);
    end
    in_a  = W'(a);
    in_b  = W'(b);
    start = 1'b1;
    e.a = a; e.b = b; e.q = eq; e.r = er; e.z = ez; e.dz = edz;
    e.lat    = (b == 0) ? 1 : W + 1;
    e.busy_n = (b == 0) ? 0 : W;
    e.acc    = cyc;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a  = ~W'(a);
    in_b  = ~W'(b);
    if (b != 0) begin
      check("hold_quotient",  int'(Quotient),  prev_q);
      check("hold_remainder", int'(Remainder), prev_r);
    end
    if (push) begin
      prev_q = eq;
      prev_r = er;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int mq, mr;
    rst   = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    issue(13, 4, 3, 1, 0, 0, 1'b1);
    issue(15, 1, 15, 0, 0, 0, 1'b1);
    issue(3, 7, 0, 3, 1, 0, 1'b1);
    issue(9, 0, 15, 9, 0, 1, 1'b1);

    // Second start during CALC must be ignored.
    issue(12, 5, 2, 2, 0, 0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    in_a  = 4'd1;
    in_b  = 4'd1;
    @(negedge clk);
    start = 1'b0;

    // Abort in the second CALC cycle; no done may follow.
    issue(14, 3, 4, 2, 0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_q = 0;
    prev_r = 0;
    issue(14, 3, 4, 2, 0, 0, 1'b1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          mq = 15;
          mr = a;
        end else begin
          mq = a / b;
          mr = a % b;
        end
        issue(a, b, mq, mr, (b != 0 && mq == 0) ? 1 : 0, (b == 0) ? 1 : 0, 1'b1);
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending results, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
